sistema_speed_multi: RTL and testbench
======================================

# sistema_speed_multi

Parametrised multi-lane nonce search engine for the micro-hash miner. It evaluates `LANES` consecutive nonces per cycle against a payload over a programmable nonce range. It reports the lowest qualifying nonce and its hash, or reports that the range was exhausted. It is the top-level search block that host/testbench logic drives directly.

## Interface
- `LANES`, 4: parallel hash lanes; power of two, 1..16
- `PAYLOAD_W`, 96: payload width
- `NONCE_W`, 32: nonce width
- `HASH_W`, 24: hash width
- `TARGET_W`, 8: target width; compared against the top `TARGET_W` bits of the hash
- `LANE_LAT`, 2: pipeline latency of one `hash_lane`, in cycles (≥1)

Ports:
- `clk`  in  1  clock; single clock domain; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `active`  in  1  level; high = search requested; low = abort / acknowledge
- `payload`  in  PAYLOAD_W  block data; sampled at search start
- `target`  in  TARGET_W  difficulty; sampled at search start
- `nonce_start`  in  NONCE_W  first nonce; sampled at search start
- `nonce_limit`  in  NONCE_W  last nonce, inclusive; sampled at search start
- `terminado`  out  1  search finished; high in DONE
- `encontrado`  out  1  a qualifying nonce was found; valid while `terminado`=1
- `nonceOut`  out  NONCE_W  winning nonce
- `hashOut`  out  HASH_W  hash of the winning nonce

## Operation
- Reset value of every output is 0. FSM goes to IDLE, and all lane valid bits are cleared. Reset mid-search discards all in-flight results.
- Hash input is `{payload, nonce}`. The hash is `micro_hash_pkg::micro_hash()`.
- Success condition: `hash[HASH_W-1 -: TARGET_W] < target`. As a result, `target`=0 never succeeds.
- FSM states:
  - **IDLE**
    - `active`=1 → latch `payload`, `target`, `nonce_start`, `nonce_limit`.
    - Load `base`=`nonce_start`.
    - Go to SEARCH.
  - **SEARCH**
    - Each cycle, issue a batch: lane i gets nonce `base+i`.
    - Lane i is valid only if `base+i ≤ limit`. Compare at NONCE_W+1 bits, so there is no wrap to 0.
    - `base += LANES`.
    - When the next `base` exceeds `limit` (NONCE_W+1-bit compare), go to DRAIN.
  - **DRAIN**
    - No issue. Count `LANE_LAT` cycles.
    - Then go to DONE with `encontrado`=0.
  - **DONE**
    - `terminado`=1. Outputs hold.
    - `active`=0 → IDLE, and outputs clear to 0 on that transition.
- Hit handling applies in SEARCH or DRAIN:
  - When any valid lane result succeeds, select the lowest lane index, which is also the smallest nonce.
  - Register `nonceOut`, `hashOut`, `encontrado`=1, then go to DONE.
  - All later in-flight batches are discarded. Batches emerge in issue order, so the reported nonce is the global minimum qualifying nonce in the range.
- Simultaneous events:
  - A hit in the same cycle as the SEARCH→DRAIN or DRAIN→DONE(no-hit) transition: the hit wins.
  - `active`=0 in SEARCH or DRAIN: abort. Next state is IDLE, lanes are flushed, and `terminado` stays 0.
  - `reset` overrides everything.
- `nonce_start > nonce_limit`: no batch is issued, the FSM passes through DRAIN, and it reaches DONE with `encontrado`=0.
- Input changes after start are ignored until the next IDLE→SEARCH transition.

## Timing
- Edge E0 samples `active`=1 in IDLE. The first batch enters the lanes at E1.
- A batch entering at edge Ek has its result at the lane output after `LANE_LAT` edges. `terminado`/`nonceOut`/`hashOut` are registered one edge later, at Ek+LANE_LAT+1.
- Hit in batch 0 → `terminado` is high after edge E0+LANE_LAT+2.
- No-hit completion with B batches: `terminado` is high after edge E0+B+LANE_LAT+1.
- Throughput is `LANES` nonces per cycle with no bubbles.
- DONE→IDLE takes one cycle. A new search can start on the edge after `active` has been seen low in DONE.

## Configuration
- `SISTEMA_STATS_EN` defined:
  - Adds output port `intentos` (out, 32): count of valid nonces whose results left the lanes during this search, including the winning batch in full.
  - Resets to 0 on `reset` and on IDLE→SEARCH. Holds in DONE. Saturates at 32'hFFFFFFFF.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `micro_hash_pkg` contains:
  - function `micro_hash`
  - default width constants (`PAYLOAD_W`, `NONCE_W`, `HASH_W`, `TARGET_W`)
  - state encoding typedef/localparams (IDLE, SEARCH, DRAIN, DONE)
- Sub-module `hash_lane`:
  - One instance per lane.
  - Data: `{payload, nonce}` + valid in.
  - Computes the hash over a `LANE_LAT`-stage pipeline.
  - Outputs registered nonce, hash, valid, and a `hit` flag (target compare inside the lane).
  - A synchronous `flush` clears all stage valids.
- The top level contains the FSM, the base/limit arithmetic, the lowest-index priority select, and the stats counter.

## Test plan
- Reset mid-search: start a search with LANES=4 and `target`=0, then pulse `reset` at cycle 3 → all outputs are 0 the next cycle; FSM is in IDLE; no `terminado` follows.
- Exhaustion: `nonce_start`=0, `nonce_limit`=9, `target`=8'h00, LANES=4 → 3 batches; `terminado`=1 with `encontrado`=0 after edge E0+3+LANE_LAT+1; `intentos`=10.
- Golden match: `payload`=96'h397d9f2f40ca9e6c6b1f3324, `target`=8'h0a, `nonce_start`=0, `nonce_limit`=32'hFFFFFFFF → `nonceOut`/`hashOut` equal the lowest nonce from a software model. Results are identical for LANES=1, 4, and 16.
- Same-batch multi-hit: `target`=8'hFF with a payload where the model reports ≥2 hits in batch 0 → `nonceOut`=`nonce_start` + lowest hitting lane index; `terminado` is high after edge E0+LANE_LAT+2.
- Top-of-range: `nonce_start`=32'hFFFFFFFE, `nonce_limit`=32'hFFFFFFFF, `target`=0, LANES=4 → only 2 nonces evaluated (`intentos`=2); no lane ever sees nonce 0; `encontrado`=0.
- Abort and restart: drop `active` during SEARCH → IDLE next cycle with `terminado`=0. Re-raise `active` → a fresh search from `nonce_start` returns the same result as an uninterrupted run.

Source files
------------

// File: rtl/micro_hash_pkg.sv
// micro_hash_pkg: shared definitions for the micro-hash nonce search engine.
//   - default width constants for payload, nonce, hash and target
//   - search FSM state encoding
//   - micro_hash(): 32-bit FNV-1a over the {payload, nonce} bytes (MSB byte
//     first), followed by an xor-shift/multiply finaliser, truncated to the
//     default hash width.
package micro_hash_pkg;

  localparam int DEF_PAYLOAD_W = 96;
  localparam int DEF_NONCE_W   = 32;
  localparam int DEF_HASH_W    = 24;
  localparam int DEF_TARGET_W  = 8;
  localparam int HASH_IN_W     = DEF_PAYLOAD_W + DEF_NONCE_W;

  localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME  = 32'h01000193;
  localparam logic [31:0] MIX_MULT   = 32'h2C1B3C6D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } search_state_e;

  function automatic logic [DEF_HASH_W-1:0] micro_hash(input logic [HASH_IN_W-1:0] data);
    logic [31:0] h;
    h = FNV_OFFSET;
    for (int b = HASH_IN_W / 8 - 1; b >= 0; b--) begin
      h = (h ^ {24'd0, data[b*8 +: 8]}) * FNV_PRIME;
    end
    // FNV low bits mix poorly on their own; fold the high half back in.
    h = h ^ (h >> 15);
    h = h * MIX_MULT;
    h = h ^ (h >> 12);
    return h[DEF_HASH_W-1:0];
  endfunction

endpackage

// File: rtl/hash_lane.sv
// hash_lane: one hashing lane of the nonce search engine.
//   An input register captures (valid, nonce); the hash of {payload, nonce}
//   and the target compare are then carried through LANE_LAT pipeline stages.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - synchronous clear of every stage valid bit
//   valid_i     - nonce_i carries a nonce to evaluate
//   payload_i   - block data (held stable by the top while the lane is busy)
//   nonce_i     - nonce to hash
//   target_i    - difficulty; hit when hash[HASH_W-1 -: TARGET_W] < target_i
//   valid_o, nonce_o, hash_o, hit_o - registered result of the last stage
module hash_lane
  import micro_hash_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int NONCE_W   = DEF_NONCE_W,
  parameter int HASH_W    = DEF_HASH_W,
  parameter int TARGET_W  = DEF_TARGET_W,
  parameter int LANE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [NONCE_W-1:0]   nonce_i,
  input  logic [TARGET_W-1:0]  target_i,
  output logic                 valid_o,
  output logic [NONCE_W-1:0]   nonce_o,
  output logic [HASH_W-1:0]    hash_o,
  output logic                 hit_o
);

  logic               in_valid_q;
  logic [NONCE_W-1:0] in_nonce_q;
  logic [HASH_W-1:0]  hash_c;
  logic               hit_c;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= valid_i;
    end
    in_nonce_q <= nonce_i;
  end

  assign hash_c = HASH_W'(micro_hash(HASH_IN_W'({payload_i, in_nonce_q})));
  assign hit_c  = hash_c[HASH_W-1 -: TARGET_W] < target_i;

  for (genvar gi = 0; gi < LANE_LAT; gi++) begin : g_stage
    logic               valid_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [HASH_W-1:0]  hash_q;
    logic               hit_q;

    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid_q;
        end
        nonce_q <= in_nonce_q;
        hash_q  <= hash_c;
        hit_q   <= hit_c;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= g_stage[gi-1].valid_q;
        end
        nonce_q <= g_stage[gi-1].nonce_q;
        hash_q  <= g_stage[gi-1].hash_q;
        hit_q   <= g_stage[gi-1].hit_q;
      end
    end
  end

  assign valid_o = g_stage[LANE_LAT-1].valid_q;
  assign nonce_o = g_stage[LANE_LAT-1].nonce_q;
  assign hash_o  = g_stage[LANE_LAT-1].hash_q;
  assign hit_o   = g_stage[LANE_LAT-1].hit_q;

endmodule

// File: rtl/sistema_speed_multi.sv
// sistema_speed_multi: multi-lane nonce search engine.
//   Evaluates LANES consecutive nonces per cycle over [nonce_start, nonce_limit]
//   and reports the lowest nonce whose hash top bits fall below target, or
//   that the range was exhausted.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   active       - high requests a search; low aborts / acknowledges DONE
//   payload, target, nonce_start, nonce_limit - sampled when a search starts
//   terminado    - search finished (DONE)
//   encontrado   - a qualifying nonce was found (valid with terminado)
//   nonceOut, hashOut - winning nonce and its hash
//   intentos     - (only with SISTEMA_STATS_EN) nonces evaluated this search
// Optional feature macro: SISTEMA_STATS_EN adds the intentos counter/port.
module sistema_speed_multi
  import micro_hash_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int NONCE_W   = DEF_NONCE_W,
  parameter int HASH_W    = DEF_HASH_W,
  parameter int TARGET_W  = DEF_TARGET_W,
  parameter int LANE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [TARGET_W-1:0]  target,
  input  logic [NONCE_W-1:0]   nonce_start,
  input  logic [NONCE_W-1:0]   nonce_limit,
  output logic                 terminado,
  output logic                 encontrado,
  output logic [NONCE_W-1:0]   nonceOut,
  output logic [HASH_W-1:0]    hashOut
`ifdef SISTEMA_STATS_EN
  ,
  output logic [31:0]          intentos
`endif
);

  localparam int CNT_W = $clog2(LANE_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LANE_LAT);

  search_state_e        state_q, state_d;
  // base carries one extra bit so base+i and base+LANES never wrap past limit.
  logic [NONCE_W:0]     base_q, base_d, base_next;
  logic [NONCE_W-1:0]   limit_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [TARGET_W-1:0]  target_q;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
  logic [HASH_W-1:0]    hash_out_q, hash_out_d;
  logic                 start_search;
  logic                 flush_lanes;

  logic [LANES-1:0]     lane_valid_in;
  logic [LANES-1:0]     lane_valid_out;
  logic [LANES-1:0]     lane_hit_out;
  logic [NONCE_W-1:0]   lane_nonce_out [LANES];
  logic [HASH_W-1:0]    lane_hash_out  [LANES];

  logic                 hit_any;
  logic [NONCE_W-1:0]   sel_nonce;
  logic [HASH_W-1:0]    sel_hash;

  assign base_next = base_q + (NONCE_W+1)'(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [NONCE_W:0] lane_sum;
    assign lane_sum          = base_q + (NONCE_W+1)'(gi);
    assign lane_valid_in[gi] = (state_q == ST_SEARCH) && (lane_sum <= {1'b0, limit_q});

    hash_lane #(
      .PAYLOAD_W(PAYLOAD_W),
      .NONCE_W  (NONCE_W),
      .HASH_W   (HASH_W),
      .TARGET_W (TARGET_W),
      .LANE_LAT (LANE_LAT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush_lanes),
      .valid_i  (lane_valid_in[gi]),
      .payload_i(payload_q),
      .nonce_i  (lane_sum[NONCE_W-1:0]),
      .target_i (target_q),
      .valid_o  (lane_valid_out[gi]),
      .nonce_o  (lane_nonce_out[gi]),
      .hash_o   (lane_hash_out[gi]),
      .hit_o    (lane_hit_out[gi])
    );
  end

  // Lowest lane index wins: scan from the top so lower lanes overwrite.
  always_comb begin
    hit_any   = 1'b0;
    sel_nonce = '0;
    sel_hash  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_valid_out[i] && lane_hit_out[i]) begin
        hit_any   = 1'b1;
        sel_nonce = lane_nonce_out[i];
        sel_hash  = lane_hash_out[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    drain_cnt_d  = drain_cnt_q;
    found_d      = found_q;
    nonce_out_d  = nonce_out_q;
    hash_out_d   = hash_out_q;
    start_search = 1'b0;
    flush_lanes  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          start_search = 1'b1;
          base_d       = {1'b0, nonce_start};
          state_d      = ST_SEARCH;
        end
      end
      ST_SEARCH, ST_DRAIN: begin
        if (!active) begin
          state_d     = ST_IDLE;
          flush_lanes = 1'b1;
        end else if (hit_any) begin
          // A hit outranks the SEARCH->DRAIN and DRAIN->DONE moves.
          found_d     = 1'b1;
          nonce_out_d = sel_nonce;
          hash_out_d  = sel_hash;
          state_d     = ST_DONE;
          flush_lanes = 1'b1;
        end else if (state_q == ST_SEARCH) begin
          base_d = base_next;
          if (base_next > {1'b0, limit_q}) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end else if (drain_cnt_q == LAT_CNT) begin
          // LANE_LAT+1 drain cycles: the last batch still needs its
          // result evaluated on the final one.
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!active) begin
          state_d     = ST_IDLE;
          found_d     = 1'b0;
          nonce_out_d = '0;
          hash_out_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      limit_q     <= '0;
      payload_q   <= '0;
      target_q    <= '0;
      drain_cnt_q <= '0;
      found_q     <= 1'b0;
      nonce_out_q <= '0;
      hash_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      drain_cnt_q <= drain_cnt_d;
      found_q     <= found_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
      if (start_search) begin
        limit_q   <= nonce_limit;
        payload_q <= payload;
        target_q  <= target;
      end
    end
  end

  assign terminado  = (state_q == ST_DONE);
  assign encontrado = found_q;
  assign nonceOut   = nonce_out_q;
  assign hashOut    = hash_out_q;

`ifdef SISTEMA_STATS_EN
  localparam int PC_W = $clog2(LANES + 1);

  logic [PC_W-1:0] lanes_done;
  logic [32:0]     intentos_sum;
  logic [31:0]     intentos_q;

  always_comb begin
    lanes_done = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes_done = lanes_done + PC_W'(lane_valid_out[i]);
    end
  end

  assign intentos_sum = {1'b0, intentos_q} + 33'(lanes_done);

  always_ff @(posedge clk) begin
    if (reset || start_search) begin
      intentos_q <= '0;
    end else if ((state_q == ST_SEARCH || state_q == ST_DRAIN) && active) begin
      intentos_q <= intentos_sum[32] ? 32'hFFFF_FFFF : intentos_sum[31:0];
    end
  end

  assign intentos = intentos_q;
`endif

endmodule

// File: tb/tb_sistema_speed_multi.sv
module tb_sistema_speed_multi;

  localparam int LANES        = 4;
  localparam int PAYLOAD_W    = 96;
  localparam int NONCE_W      = 32;
  localparam int HASH_W       = 24;
  localparam int TARGET_W     = 8;
  localparam int LANE_LAT     = 2;
  localparam int RESULT_BOUND = 5000;
  localparam longint SEARCH_BOUND = 200000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 active = 1'b0;
  logic [PAYLOAD_W-1:0] payload = '0;
  logic [TARGET_W-1:0]  target = '0;
  logic [NONCE_W-1:0]   nonce_start = '0;
  logic [NONCE_W-1:0]   nonce_limit = '0;
  logic                 terminado;
  logic                 encontrado;
  logic [NONCE_W-1:0]   nonceOut;
  logic [HASH_W-1:0]    hashOut;
`ifdef SISTEMA_STATS_EN
  logic [31:0]          intentos;
`endif

  always #5 clk = ~clk;

  sistema_speed_multi #(
    .LANES    (LANES),
    .PAYLOAD_W(PAYLOAD_W),
    .NONCE_W  (NONCE_W),
    .HASH_W   (HASH_W),
    .TARGET_W (TARGET_W),
    .LANE_LAT (LANE_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .payload    (payload),
    .target     (target),
    .nonce_start(nonce_start),
    .nonce_limit(nonce_limit),
    .terminado  (terminado),
    .encontrado (encontrado),
    .nonceOut   (nonceOut),
    .hashOut    (hashOut)
`ifdef SISTEMA_STATS_EN
    ,
    .intentos   (intentos)
`endif
  );

  typedef struct {
    logic               found;
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
    int                 latency;
    longint             tries;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference hash: FNV-1a over the 16 bytes of {payload, nonce}, MSB first,
  // then xor-shift / multiply / xor-shift, low 24 bits.
  function automatic logic [HASH_W-1:0] model_hash(input logic [PAYLOAD_W-1:0] p,
                                                   input logic [NONCE_W-1:0] n);
    logic [127:0] m;
    logic [31:0]  h;
    m = {p, n};
    h = 32'h811C9DC5;
    for (int k = 0; k < 16; k++) begin
      h = h ^ {24'd0, m[127 - 8*k -: 8]};
      h = h * 32'd16777619;
    end
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    return h[HASH_W-1:0];
  endfunction

  // Expected outcome of a search, including edges from E0 to terminado.
  function automatic exp_t model_search(input logic [PAYLOAD_W-1:0] p,
                                        input logic [TARGET_W-1:0] t,
                                        input logic [NONCE_W-1:0] s,
                                        input logic [NONCE_W-1:0] l);
    exp_t e;
    longint span;
    longint k;
    logic [HASH_W-1:0] h;
    logic [NONCE_W-1:0] n;
    e.found = 1'b0;
    e.nonce = '0;
    e.hash = '0;
    e.tries = 0;
    e.latency = 1 + LANE_LAT + 1;
    if (s > l) return e;
    span = longint'(l) - longint'(s) + 1;
    for (longint i = 0; i < span && i < SEARCH_BOUND; i++) begin
      n = s + NONCE_W'(i);
      h = model_hash(p, n);
      if (h[HASH_W-1 -: TARGET_W] < t) begin
        k = i / LANES;
        e.found = 1'b1;
        e.nonce = n;
        e.hash = h;
        e.latency = int'(k) + LANE_LAT + 2;
        e.tries = ((k + 1) * LANES < span) ? (k + 1) * LANES : span;
        return e;
      end
    end
    k = (span + LANES - 1) / LANES;
    e.latency = int'(k) + LANE_LAT + 1;
    e.tries = span;
    return e;
  endfunction

  task automatic start_search(input logic [PAYLOAD_W-1:0] p, input logic [TARGET_W-1:0] t,
                              input logic [NONCE_W-1:0] s, input logic [NONCE_W-1:0] l,
                              input bit expect_done);
    @(negedge clk);
    payload = p;
    target = t;
    nonce_start = s;
    nonce_limit = l;
    active = 1'b1;
    if (expect_done) exp_q.push_back(model_search(p, t, s, l));
    @(posedge clk);  // E0
    #1;
    // Inputs after start must be ignored.
    payload = {$urandom, $urandom, $urandom};
    target = 8'($urandom);
    nonce_start = $urandom;
    nonce_limit = $urandom;
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int cyc;
    bit seen;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard: no expected entry, got none required 1", name);
      return;
    end
    e = exp_q.pop_front();
    seen = 0;
    cyc = 0;
    while (!seen && cyc < RESULT_BOUND) begin
      @(negedge clk);
      if (terminado) seen = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: terminado=0 after %0d cycles, required 1", name, cyc);
      return;
    end
    $display("%s: found=%0b nonce=%h hash=%h edges=%0d", name, encontrado, nonceOut, hashOut, cyc);
    checks++;
    if (cyc !== e.latency) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, cyc, e.latency);
    end
    checks++;
    if (encontrado !== e.found) begin
      failures++;
      $display("FAIL %s_encontrado: got %0b required %0b", name, encontrado, e.found);
    end
    checks++;
    if (nonceOut !== e.nonce) begin
      failures++;
      $display("FAIL %s_nonce: got %h required %h", name, nonceOut, e.nonce);
    end
    checks++;
    if (hashOut !== e.hash) begin
      failures++;
      $display("FAIL %s_hash: got %h required %h", name, hashOut, e.hash);
    end
`ifdef SISTEMA_STATS_EN
    checks++;
    if (intentos !== 32'(e.tries)) begin
      failures++;
      $display("FAIL %s_intentos: got %0d required %0d", name, intentos, e.tries);
    end
`endif
  endtask

  task automatic ack_done(input string name);
    active = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({terminado, encontrado, nonceOut, hashOut} !== '0) begin
      failures++;
      $display("FAIL %s_ack: got t=%0b e=%0b n=%h h=%h required all 0",
               name, terminado, encontrado, nonceOut, hashOut);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({terminado, encontrado, nonceOut, hashOut} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got t=%0b e=%0b n=%h h=%h required all 0",
               terminado, encontrado, nonceOut, hashOut);
    end
`ifdef SISTEMA_STATS_EN
    checks++;
    if (intentos !== 32'd0) begin
      failures++;
      $display("FAIL reset_intentos: got %0d required 0", intentos);
    end
`endif
    $display("reset: outputs t=%0b e=%0b", terminado, encontrado);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    start_search(96'h0, 8'h00, 32'd0, 32'd1000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    active = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({terminado, encontrado, nonceOut, hashOut} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got t=%0b e=%0b n=%h h=%h required all 0",
               terminado, encontrado, nonceOut, hashOut);
    end
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (terminado) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done: terminado seen=%0b required 0", seen);
    end
    $display("reset_mid_search: terminado_seen=%0b", seen);
  endtask

  task automatic test_boundaries();
    string                names [4];
    logic [TARGET_W-1:0]  tgts  [4];
    logic [NONCE_W-1:0]   starts[4];
    logic [NONCE_W-1:0]   limits[4];
    names  = '{"exhaust", "top_of_range", "empty_range", "single_nonce"};
    tgts   = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    starts = '{32'd0, 32'hFFFF_FFFE, 32'd10, 32'h55};
    limits = '{32'd9, 32'hFFFF_FFFF, 32'd5, 32'h55};
    for (int i = 0; i < 4; i++) begin
      start_search(96'hA5A5_0000_1234_5678_9ABC_DEF0, tgts[i], starts[i], limits[i], 1'b1);
      wait_result(names[i]);
      ack_done(names[i]);
    end
  endtask

  task automatic test_golden();
    start_search(96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_result("golden");
    ack_done("golden");
  endtask

  task automatic test_multi_hit();
    logic [PAYLOAD_W-1:0] p;
    logic [HASH_W-1:0]    h;
    logic [NONCE_W-1:0]   s;
    int hits;
    bit ok;
    s = 32'h1000_0000;
    ok = 0;
    p = '0;
    for (int t = 0; t < 50 && !ok; t++) begin
      p = {$urandom, $urandom, $urandom};
      hits = 0;
      for (int i = 0; i < LANES; i++) begin
        h = model_hash(p, s + NONCE_W'(i));
        if (h[HASH_W-1 -: TARGET_W] < 8'hFF) hits++;
      end
      if (hits >= 2) ok = 1;
    end
    start_search(p, 8'hFF, s, 32'hFFFF_FFFF, 1'b1);
    wait_result("multi_hit");
    ack_done("multi_hit");
  endtask

  task automatic test_abort_restart();
    logic [PAYLOAD_W-1:0] p;
    bit seen;
    p = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
    start_search(p, 8'h03, 32'd100, 32'd100000, 1'b0);
    @(negedge clk);
    active = 1'b0;  // still in SEARCH: no result can emerge this early
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (terminado) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_terminado: seen=%0b required 0", seen);
    end
    $display("abort: terminado_seen=%0b", seen);
    start_search(p, 8'h03, 32'd100, 32'd100000, 1'b1);
    wait_result("abort_restart");
    ack_done("abort_restart");
  endtask

  initial begin
    test_reset();
    test_reset_mid_search();
    test_boundaries();
    test_golden();
    test_multi_hit();
    test_abort_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
